// File: rtl/data_memory_responder.sv
// data_memory_responder
//   Responder end of the CPU data-memory bus. Serves CPU loads and stores
//   from a word-addressed on-chip RAM. It uses a request/ready handshake with
//   a configurable number of wait states. Stores have byte-lane selects.
//   A bad address is answered with an error response.
//
// Ports
//   i_clock         sole clock, rising edge
//   i_reset         synchronous, active-high
//   i_request       initiator holds high with stable fields until o_ready
//   i_write_enable  1 = store, 0 = load
//   i_address       byte address, bits [1:0] must be 0
//   i_select        byte lanes, i_select[3] = data[31:24] ... i_select[0] = data[7:0]
//   i_write_data    lane-aligned store data
//   o_read_data     load data, held until the next load completes
//   o_ready         single-cycle completion pulse
//   o_error         qualified by o_ready, 1 = request rejected
module data_memory_responder #(
    parameter int          ADDR_WIDTH   = 10,
    parameter int          WAIT_STATES  = 1,
    parameter logic [31:0] BASE_ADDRESS = 32'h0000_0000
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_request,
    input  logic        i_write_enable,
    input  logic [31:0] i_address,
    input  logic [3:0]  i_select,
    input  logic [31:0] i_write_data,
    output logic [31:0] o_read_data,
    output logic        o_ready,
    output logic        o_error
);

    localparam int         DEPTH    = 1 << ADDR_WIDTH;
    localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESPOND} state_t;

    state_t      r_state, w_state_next;
    logic [3:0]  r_cnt, w_cnt_next;
    logic        r_we;
    logic [31:0] r_addr;
    logic [3:0]  r_sel;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic [31:0] r_mem [DEPTH];

    // Access fields come from the bus while in IDLE and from the latched copy
    // afterwards. With zero wait states, the access happens at the same edge
    // that accepts the request.
    logic                  w_idle;
    logic                  w_acc_we;
    logic [31:0]           w_acc_addr;
    logic [3:0]            w_acc_sel;
    logic [31:0]           w_acc_wdata;
    logic [32:0]           w_off;
    logic                  w_bad;
    logic [ADDR_WIDTH-1:0] w_idx;
    logic                  w_enter_resp;

    assign w_idle      = (r_state == S_IDLE);
    assign w_acc_we    = w_idle ? i_write_enable : r_we;
    assign w_acc_addr  = w_idle ? i_address      : r_addr;
    assign w_acc_sel   = w_idle ? i_select       : r_sel;
    assign w_acc_wdata = w_idle ? i_write_data   : r_wdata;

    // The 33-bit subtract exposes a borrow, which flags addresses below the base.
    // The range check runs before truncation, so high addresses cannot alias
    // back into the RAM.
    assign w_off = {1'b0, w_acc_addr} - {1'b0, BASE_ADDRESS};
    assign w_bad = (w_acc_addr[1:0] != 2'b00) || w_off[32] || (|w_off[31:ADDR_WIDTH+2]);
    assign w_idx = w_off[ADDR_WIDTH+1:2];

    // A reset at the edge that would enter RESPOND aborts the access.
    assign w_enter_resp = (w_state_next == S_RESPOND) && (r_state != S_RESPOND) && !i_reset;

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (i_request) begin
                    w_cnt_next   = CNT_INIT;
                    w_state_next = (WAIT_STATES > 0) ? S_WAIT : S_RESPOND;
                end
            end
            S_WAIT: begin
                if (!i_request)
                    w_state_next = S_IDLE;
                else if (r_cnt == 4'd0)
                    w_state_next = S_RESPOND;
                else
                    w_cnt_next = r_cnt - 4'd1;
            end
            S_RESPOND: w_state_next = S_IDLE;
            default:   w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_rdata <= 32'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            if (w_enter_resp && !w_acc_we && !w_bad)
                r_rdata <= r_mem[w_idx];
        end
    end

    // Request fields are latched once on acceptance. Later changes on the bus are ignored.
    always_ff @(posedge i_clock) begin
        if (w_idle && i_request) begin
            r_we    <= i_write_enable;
            r_addr  <= i_address;
            r_sel   <= i_select;
            r_wdata <= i_write_data;
        end
    end

    // RAM contents are not cleared by reset.
    always_ff @(posedge i_clock) begin
        if (w_enter_resp && w_acc_we && !w_bad) begin
            for (int b = 0; b < 4; b++)
                if (w_acc_sel[b])
                    r_mem[w_idx][8*b +: 8] <= w_acc_wdata[8*b +: 8];
        end
    end

    assign o_ready     = (r_state == S_RESPOND);
    assign o_error     = o_ready && w_bad;
    assign o_read_data = r_rdata;

endmodule

// File: tb/tb_data_memory_responder.sv
module tb_data_memory_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req1, req3, we;
    logic [31:0] addr, wdata;
    logic [3:0]  sel;
    logic [31:0] rd1, rd3;
    logic        rdy1, err1, rdy3, err3;

    int passed = 0;
    int fails  = 0;
    int total  = 0;

    always #5 clk = ~clk;

    data_memory_responder #(.ADDR_WIDTH(10), .WAIT_STATES(1), .BASE_ADDRESS(32'h0)) dut1 (
        .i_clock(clk), .i_reset(rst), .i_request(req1), .i_write_enable(we),
        .i_address(addr), .i_select(sel), .i_write_data(wdata),
        .o_read_data(rd1), .o_ready(rdy1), .o_error(err1));

    data_memory_responder #(.ADDR_WIDTH(10), .WAIT_STATES(3), .BASE_ADDRESS(32'h2000)) dut3 (
        .i_clock(clk), .i_reset(rst), .i_request(req3), .i_write_enable(we),
        .i_address(addr), .i_select(sel), .i_write_data(wdata),
        .o_read_data(rd3), .o_ready(rdy3), .o_error(err3));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one request on the chosen responder and wait for ready.
    // lat counts edges from the acceptance edge (inclusive) to the edge that raises ready.
    task automatic access(input int which, input logic w, input logic [31:0] a,
                          input logic [3:0] s, input logic [31:0] d,
                          output int lat, output logic [31:0] rdo, output logic erro,
                          output logic after_rdy);
        logic r;
        @(negedge clk);
        we = w; addr = a; sel = s; wdata = d;
        if (which == 1) req1 = 1'b1; else req3 = 1'b1;
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            r = (which == 1) ? rdy1 : rdy3;
        end while (!r && lat < 40);
        rdo  = (which == 1) ? rd1 : rd3;
        erro = (which == 1) ? err1 : err3;
        req1 = 1'b0; req3 = 1'b0;
        @(negedge clk);
        after_rdy = (which == 1) ? rdy1 : rdy3;
    endtask

    initial begin
        int          lat;
        logic [31:0] rdv;
        logic        e, ar, any;

        rst = 1'b1; req1 = 1'b0; req3 = 1'b0; we = 1'b0;
        addr = 32'h0; sel = 4'h0; wdata = 32'h0;

        // Reset and idle: all outputs quiet.
        any = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            any = any | rdy1 | err1 | rdy3 | err3 | (|rd1) | (|rd3);
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            any = any | rdy1 | err1 | rdy3 | err3 | (|rd1) | (|rd3);
        end
        check("reset_idle_quiet", {31'd0, any}, 32'd0);
        check("reset_rd1", rd1, 32'h0);

        // WAIT_STATES=1: full-word store then load.
        access(1, 1'b1, 32'h10, 4'hF, 32'h12345678, lat, rdv, e, ar);
        check("st_full_lat", lat, 2);
        check("st_full_err", {31'd0, e}, 0);
        check("st_full_pulse", {31'd0, ar}, 0);
        check("st_rd_unchanged", rdv, 32'h0);
        access(1, 1'b0, 32'h10, 4'hF, 32'h0, lat, rdv, e, ar);
        check("ld_full_lat", lat, 2);
        check("ld_full_data", rdv, 32'h12345678);

        // Single-lane store: only data[15:8] changes.
        access(1, 1'b1, 32'h10, 4'b0010, 32'h0000AB00, lat, rdv, e, ar);
        check("st_lane_rd_held", rdv, 32'h12345678);
        access(1, 1'b0, 32'h10, 4'hF, 32'h0, lat, rdv, e, ar);
        check("ld_lane_data", rdv, 32'h1234AB78);

        // select=0000 store is a no-op.
        access(1, 1'b1, 32'h10, 4'b0000, 32'hFFFFFFFF, lat, rdv, e, ar);
        check("st_nolane_err", {31'd0, e}, 0);
        access(1, 1'b0, 32'h10, 4'hF, 32'h0, lat, rdv, e, ar);
        check("ld_after_nolane", rdv, 32'h1234AB78);

        // Error responses: misaligned and out of range.
        access(1, 1'b0, 32'h12, 4'hF, 32'h0, lat, rdv, e, ar);
        check("ld_misalign_err", {31'd0, e}, 1);
        check("ld_misalign_lat", lat, 2);
        check("ld_misalign_rd", rdv, 32'h1234AB78);
        access(1, 1'b0, 32'h1000, 4'hF, 32'h0, lat, rdv, e, ar);
        check("ld_oor_err", {31'd0, e}, 1);
        access(1, 1'b1, 32'h1010, 4'hF, 32'hFFFFFFFF, lat, rdv, e, ar);
        check("st_oor_err", {31'd0, e}, 1);
        access(1, 1'b1, 32'h12, 4'hF, 32'hFFFFFFFF, lat, rdv, e, ar);
        check("st_misalign_err", {31'd0, e}, 1);
        access(1, 1'b0, 32'h10, 4'hF, 32'h0, lat, rdv, e, ar);
        check("ld_after_err_data", rdv, 32'h1234AB78);
        check("ld_after_err_flag", {31'd0, e}, 0);

        // Reset pulsed while a store sits in WAIT: no ready, no write.
        @(negedge clk);
        we = 1'b1; addr = 32'h10; sel = 4'hF; wdata = 32'hFFFFFFFF; req1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        any = rdy1;
        check("rst_wait_rd", rd1, 32'h0);
        rst = 1'b0; req1 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            any = any | rdy1;
        end
        check("rst_wait_no_ready", {31'd0, any}, 0);
        access(1, 1'b0, 32'h10, 4'hF, 32'h0, lat, rdv, e, ar);
        check("ld_after_rst", rdv, 32'h1234AB78);

        // WAIT_STATES=3, base 0x2000.
        access(3, 1'b1, 32'h2020, 4'hF, 32'hCAFEF00D, lat, rdv, e, ar);
        check("ws3_st_lat", lat, 4);
        check("ws3_st_err", {31'd0, e}, 0);
        access(3, 1'b0, 32'h2020, 4'hF, 32'h0, lat, rdv, e, ar);
        check("ws3_ld_lat", lat, 4);
        check("ws3_ld_data", rdv, 32'hCAFEF00D);
        check("ws3_ld_pulse", {31'd0, ar}, 0);
        any = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            any = any | rdy3;
        end
        check("ws3_held_data", rd3, 32'hCAFEF00D);
        check("ws3_held_noready", {31'd0, any}, 0);

        // Below base and above window on the offset responder.
        access(3, 1'b0, 32'h10, 4'hF, 32'h0, lat, rdv, e, ar);
        check("ws3_below_base_err", {31'd0, e}, 1);
        access(3, 1'b0, 32'h3000, 4'hF, 32'h0, lat, rdv, e, ar);
        check("ws3_above_err", {31'd0, e}, 1);
        check("ws3_err_rd_held", rdv, 32'hCAFEF00D);

        // Request dropped during WAIT: abandoned, no ready.
        @(negedge clk);
        we = 1'b0; addr = 32'h2010; sel = 4'hF; req3 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req3 = 1'b0;
        any = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            any = any | rdy3;
        end
        check("ws3_drop_no_ready", {31'd0, any}, 0);
        check("ws3_drop_rd_held", rd3, 32'hCAFEF00D);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
